// File: rtl/fp_add_arbiter_pkg.sv
// fp_add_arbiter_pkg: field layout and FSM encoding shared by the arbiter slice.
// Revision 1.0
`default_nettype none

package fp_add_arbiter_pkg;

   localparam int SIGN_BIT = 31;
   localparam int EXP_MSB  = 30;
   localparam int EXP_LSB  = 23;
   localparam int FRAC_W   = 23;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

endpackage

`default_nettype wire

// File: rtl/fp_add_arbiter_if.sv
// fp_add_arbiter_if: request/response handshakes of the two adder clients.
// Revision 1.0
`default_nettype none

interface fp_add_arbiter_if #(
   parameter int DATA_W = 32
);
   logic              req0_valid;
   logic              req0_ready;
   logic [DATA_W-1:0] req0_a;
   logic [DATA_W-1:0] req0_b;
   logic              resp0_valid;
   logic              resp0_ready;

   logic              req1_valid;
   logic              req1_ready;
   logic [DATA_W-1:0] req1_a;
   logic [DATA_W-1:0] req1_b;
   logic              resp1_valid;
   logic              resp1_ready;

   logic [DATA_W-1:0] resp_result;

   modport master (
      output req0_valid, req0_a, req0_b, resp0_ready,
      output req1_valid, req1_a, req1_b, resp1_ready,
      input  req0_ready, resp0_valid, req1_ready, resp1_valid, resp_result
   );

   modport slave (
      input  req0_valid, req0_a, req0_b, resp0_ready,
      input  req1_valid, req1_a, req1_b, resp1_ready,
      output req0_ready, resp0_valid, req1_ready, resp1_valid, resp_result
   );
endinterface

`default_nettype wire

// File: rtl/fp_rr_grant2.sv
// fp_rr_grant2: combinational two-way round-robin grant.
// Revision 1.0
`default_nettype none

module fp_rr_grant2 (
   input  logic i_valid0,
   input  logic i_valid1,
   input  logic i_last_grant,
   output logic o_grant_vld,
   output logic o_grant
);
   assign o_grant_vld = i_valid0 | i_valid1;
   // On a tie the requester that did not win last time gets the slot.
   assign o_grant     = (i_valid0 & i_valid1) ? ~i_last_grant : i_valid1;
endmodule

`default_nettype wire

// File: rtl/fp_add_arbiter.sv
// fp_add_arbiter: two-client round-robin sequencer for the shared combinational FP adder.
// Revision 1.0
`default_nettype none

module fp_add_arbiter
   import fp_add_arbiter_pkg::*;
#(
   parameter int ADDER_LAT = 1,
   parameter int DATA_W    = 32
) (
   input  logic                     clk,
   input  logic                     rst_n,
   fp_add_arbiter_if.slave          bus,
   output logic [DATA_W-1:0]        flp_a,
   output logic [DATA_W-1:0]        flp_b,
   input  logic                     add_sign,
   input  logic [EXP_MSB-EXP_LSB:0] add_exponent,
   input  logic [FRAC_W-1:0]        add_sum
);
   localparam int               CNT_W    = (ADDER_LAT > 1) ? $clog2(ADDER_LAT) : 1;
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(ADDER_LAT - 1);

   state_t            r_state;
   state_t            w_state_nxt;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_owner;
   logic              r_last_grant;
   logic [DATA_W-1:0] r_flp_a;
   logic [DATA_W-1:0] r_flp_b;
   logic [DATA_W-1:0] r_result;
   logic [DATA_W-1:0] w_result;
   logic              w_grant_vld;
   logic              w_grant;
   logic              w_accept;
   logic              w_cnt_done;

   fp_rr_grant2 u_grant (
      .i_valid0     (bus.req0_valid),
      .i_valid1     (bus.req1_valid),
      .i_last_grant (r_last_grant),
      .o_grant_vld  (w_grant_vld),
      .o_grant      (w_grant)
   );

   assign w_cnt_done = (r_cnt == '0);

   always_comb begin
      w_result                  = '0;
      w_result[SIGN_BIT]        = add_sign;
      w_result[EXP_MSB:EXP_LSB] = add_exponent;
      w_result[FRAC_W-1:0]      = add_sum;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_accept        = 1'b0;
      bus.req0_ready  = 1'b0;
      bus.req1_ready  = 1'b0;
      bus.resp0_valid = 1'b0;
      bus.resp1_valid = 1'b0;
      case (r_state)
         IDLE: begin
            // Ready is combinational from valid, so it is masked while reset is held.
            bus.req0_ready = rst_n & w_grant_vld & ~w_grant;
            bus.req1_ready = rst_n & w_grant_vld & w_grant;
            if (w_grant_vld) begin
               w_accept    = 1'b1;
               w_state_nxt = WAIT;
            end
         end
         WAIT: begin
            if (w_cnt_done) begin
               w_state_nxt = RESP;
            end
         end
         RESP: begin
            bus.resp0_valid = ~r_owner;
            bus.resp1_valid = r_owner;
            if ((~r_owner & bus.resp0_ready) | (r_owner & bus.resp1_ready)) begin
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_flp_a      <= '0;
         r_flp_b      <= '0;
         r_result     <= '0;
         r_cnt        <= '0;
         r_owner      <= 1'b0;
         r_last_grant <= 1'b1;
      end else if (w_accept) begin
         r_flp_a      <= w_grant ? bus.req1_a : bus.req0_a;
         r_flp_b      <= w_grant ? bus.req1_b : bus.req0_b;
         r_owner      <= w_grant;
         r_last_grant <= w_grant;
         r_cnt        <= CNT_INIT;
      end else if (r_state == WAIT) begin
         if (w_cnt_done) begin
            r_result <= w_result;
         end else begin
            r_cnt <= r_cnt - 1'b1;
         end
      end
   end

   assign flp_a           = r_flp_a;
   assign flp_b           = r_flp_b;
   assign bus.resp_result = r_result;

endmodule

`default_nettype wire

// File: tb/tb_fp_add_arbiter.sv
// tb_fp_add_arbiter: randomized and directed checks of fp_add_arbiter against a transaction model.
// Revision 1.0
`default_nettype none

module tb_fp_add_arbiter;
   localparam int MLAT = 1;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] flp_a, flp_b, flp_a3, flp_b3;
   logic        add_sign, add3_sign;
   logic [7:0]  add_exponent, add3_exponent;
   logic [22:0] add_sum, add3_sum;

   fp_add_arbiter_if #(.DATA_W(32)) bus  ();
   fp_add_arbiter_if #(.DATA_W(32)) bus3 ();

   fp_add_arbiter #(.ADDER_LAT(MLAT), .DATA_W(32)) u_dut (
      .clk(clk), .rst_n(rst_n), .bus(bus), .flp_a(flp_a), .flp_b(flp_b),
      .add_sign(add_sign), .add_exponent(add_exponent), .add_sum(add_sum)
   );

   fp_add_arbiter #(.ADDER_LAT(3), .DATA_W(32)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .bus(bus3), .flp_a(flp_a3), .flp_b(flp_b3),
      .add_sign(add3_sign), .add_exponent(add3_exponent), .add_sum(add3_sum)
   );

   always #5 clk = ~clk;

   // Stand-in adder: positive/same-sign normal values, exponent bias 1, truncating.
   function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
      logic [31:0] x, y;
      logic [23:0] mx, my;
      logic [24:0] s;
      logic [7:0]  e;
      int          d;
      if (a[30:23] >= b[30:23]) begin x = a; y = b; end
      else begin x = b; y = a; end
      d  = int'(x[30:23]) - int'(y[30:23]);
      mx = {1'b1, x[22:0]};
      my = (d >= 24) ? 24'd0 : ({1'b1, y[22:0]} >> d);
      s  = {1'b0, mx} + {1'b0, my};
      e  = x[30:23];
      if (s[24]) begin s = s >> 1; e = e + 8'd1; end
      return {x[31], e, s[22:0]};
   endfunction

   assign {add_sign, add_exponent, add_sum}    = fadd(flp_a, flp_b);
   assign {add3_sign, add3_exponent, add3_sum} = fadd(flp_a3, flp_b3);

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] rand_fp();
      return {1'b0, 8'($urandom_range(1, 200)), 23'($urandom)};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Transaction model: one op in flight, result visible MLAT+1 negedges after acceptance.
   bit          m_busy = 1'b0;
   int          m_owner = 0;
   int          m_last = 1;
   int          m_wait = 0;
   logic [31:0] m_a = '0, m_b = '0, m_shown = '0;
   int          g_log[$];

   initial begin : model_compare
      bit v0, v1, e_gv, e_rv;
      int e_g;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            m_busy = 1'b0; m_owner = 0; m_last = 1; m_wait = 0;
            m_a = '0; m_b = '0; m_shown = '0;
         end else begin
            v0   = bus.req0_valid;
            v1   = bus.req1_valid;
            e_gv = !m_busy && (v0 || v1);
            e_g  = (v0 && v1) ? ((m_last == 0) ? 1 : 0) : (v1 ? 1 : 0);
            e_rv = m_busy && (m_wait == 0);
            chk("req0_ready",  32'(bus.req0_ready),  32'(e_gv && e_g == 0));
            chk("req1_ready",  32'(bus.req1_ready),  32'(e_gv && e_g == 1));
            chk("resp0_valid", 32'(bus.resp0_valid), 32'(e_rv && m_owner == 0));
            chk("resp1_valid", 32'(bus.resp1_valid), 32'(e_rv && m_owner == 1));
            chk("resp_result", bus.resp_result, m_shown);
            chk("flp_a", flp_a, m_a);
            chk("flp_b", flp_b, m_b);
            if (e_rv) begin
               if ((m_owner == 0 && bus.resp0_ready) || (m_owner == 1 && bus.resp1_ready))
                  m_busy = 1'b0;
            end else if (m_busy) begin
               m_wait--;
               if (m_wait == 0) m_shown = fadd(m_a, m_b);
            end else if (e_gv) begin
               m_busy  = 1'b1;
               m_owner = e_g;
               m_last  = e_g;
               m_wait  = MLAT;
               m_a     = (e_g == 1) ? bus.req1_a : bus.req0_a;
               m_b     = (e_g == 1) ? bus.req1_b : bus.req0_b;
               g_log.push_back(e_g);
            end
         end
      end
   end

   initial begin : stimulus
      int          seen;
      bit          got;
      logic [31:0] held;
      int          exp_ord[4];
      exp_ord = '{0, 1, 0, 1};

      bus.req0_valid = 0; bus.req0_a = '0; bus.req0_b = '0; bus.resp0_ready = 0;
      bus.req1_valid = 0; bus.req1_a = '0; bus.req1_b = '0; bus.resp1_ready = 0;
      bus3.req0_valid = 0; bus3.req0_a = '0; bus3.req0_b = '0; bus3.resp0_ready = 0;
      bus3.req1_valid = 0; bus3.req1_a = '0; bus3.req1_b = '0; bus3.resp1_ready = 0;

      chk("fadd_pin_12p35", fadd(32'h02400000, 32'h030C0000), 32'h033C0000);

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_flp_a", flp_a, 32'h0);
      chk("rst_flp_b", flp_b, 32'h0);
      chk("rst_result", bus.resp_result, 32'h0);
      chk("rst_valids", 32'({bus.req0_ready, bus.req1_ready, bus.resp0_valid, bus.resp1_valid}), 32'h0);
      chk("rst3_flp_a", flp_a3, 32'h0);
      chk("rst3_result", bus3.resp_result, 32'h0);
      rst_n = 1'b1;
      tick();

      // ADDER_LAT=3 instance: response exactly three edges after acceptance
      bus3.req0_valid = 1; bus3.req0_a = 32'h02400000; bus3.req0_b = 32'h030C0000;
      #1;
      chk("lat3_ready", 32'(bus3.req0_ready), 32'd1);
      tick();
      bus3.req0_valid = 0;
      for (int e = 1; e <= 3; e++) begin
         tick();
         chk("lat3_resp_valid", 32'(bus3.resp0_valid), 32'(e == 3));
         chk("lat3_flp_a", flp_a3, 32'h02400000);
         chk("lat3_flp_b", flp_b3, 32'h030C0000);
      end
      chk("lat3_result", bus3.resp_result, 32'h033C0000);
      chk("lat3_resp1_valid", 32'(bus3.resp1_valid), 32'd0);
      bus3.resp0_ready = 1;
      tick();
      bus3.resp0_ready = 0;
      chk("lat3_resp_done", 32'(bus3.resp0_valid), 32'd0);

      // Single op from requester 0: 12 + 35 = 47
      bus.req0_valid = 1; bus.req0_a = 32'h02400000; bus.req0_b = 32'h030C0000;
      #1;
      chk("single_req0_ready", 32'(bus.req0_ready), 32'd1);
      tick();
      bus.req0_valid = 0;
      chk("single_resp0_early", 32'(bus.resp0_valid), 32'd0);
      tick();
      chk("single_resp0_valid", 32'(bus.resp0_valid), 32'd1);
      chk("single_result", bus.resp_result, 32'h033C0000);
      chk("single_resp1_valid", 32'(bus.resp1_valid), 32'd0);
      bus.resp0_ready = 1;
      tick();
      bus.resp0_ready = 0;

      // Reset while requester 0's op is in WAIT
      bus.req0_valid = 1; bus.req0_a = rand_fp(); bus.req0_b = rand_fp();
      tick();
      bus.req0_valid = 0;
      bus.req1_valid = 1; bus.req1_a = rand_fp(); bus.req1_b = rand_fp();
      #2;
      rst_n = 1'b0;
      #1;
      chk("rstw_req1_ready", 32'(bus.req1_ready), 32'd0);
      chk("rstw_resp0_valid", 32'(bus.resp0_valid), 32'd0);
      chk("rstw_flp_a", flp_a, 32'h0);
      chk("rstw_flp_b", flp_b, 32'h0);
      chk("rstw_result", bus.resp_result, 32'h0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      bus.resp1_ready = 1;
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (bus.resp0_valid) seen++;
      end
      chk("rstw_no_resp0", 32'(seen), 32'd0);
      bus.req1_valid = 0;
      repeat (4) tick();
      bus.resp1_ready = 0;

      // Fairness with both requesters continuously valid
      g_log.delete();
      bus.req0_valid = 1; bus.req1_valid = 1;
      bus.resp0_ready = 1; bus.resp1_ready = 1;
      for (int i = 0; i < 60 && g_log.size() < 4; i++) begin
         bus.req0_a = rand_fp(); bus.req0_b = rand_fp();
         bus.req1_a = rand_fp(); bus.req1_b = rand_fp();
         tick();
      end
      bus.req0_valid = 0; bus.req1_valid = 0;
      chk("fair_grant_count", 32'(g_log.size() >= 4), 32'd1);
      for (int i = 0; i < 4; i++)
         chk("fair_order", 32'((i < g_log.size()) ? g_log[i] : -1), 32'(exp_ord[i]));
      repeat (4) tick();
      bus.resp0_ready = 0; bus.resp1_ready = 0;

      // Backpressure on requester 1's response
      bus.req1_valid = 1; bus.req1_a = rand_fp(); bus.req1_b = rand_fp();
      got = 0;
      for (int i = 0; i < 10; i++) begin
         #1;
         got = bus.req1_ready;
         tick();
         if (got) break;
      end
      chk("bp_accept", 32'(got), 32'd1);
      bus.req1_valid = 0;
      bus.req0_valid = 1; bus.req0_a = rand_fp(); bus.req0_b = rand_fp();
      for (int i = 0; i < 10; i++) begin
         if (bus.resp1_valid) break;
         tick();
      end
      chk("bp_resp1_seen", 32'(bus.resp1_valid), 32'd1);
      held = bus.resp_result;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("bp_resp1_hold", 32'(bus.resp1_valid), 32'd1);
         chk("bp_result_hold", bus.resp_result, held);
         chk("bp_req0_blocked", 32'(bus.req0_ready), 32'd0);
      end
      bus.resp1_ready = 1;
      tick();
      bus.resp1_ready = 0;
      chk("bp_req0_after", 32'(bus.req0_ready), 32'd1);
      tick();
      bus.req0_valid = 0;
      bus.resp0_ready = 1;
      repeat (4) tick();
      bus.resp0_ready = 0;

      // Randomized traffic checked cycle by cycle by the model
      for (int i = 0; i < 1500; i++) begin
         bus.req0_valid  = ($urandom_range(0, 2) != 0);
         bus.req1_valid  = ($urandom_range(0, 2) != 0);
         bus.req0_a      = rand_fp(); bus.req0_b = rand_fp();
         bus.req1_a      = rand_fp(); bus.req1_b = rand_fp();
         bus.resp0_ready = ($urandom_range(0, 1) != 0);
         bus.resp1_ready = ($urandom_range(0, 1) != 0);
         tick();
      end
      bus.req0_valid = 0; bus.req1_valid = 0;
      bus.resp0_ready = 1; bus.resp1_ready = 1;
      repeat (5) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/fp_add_arbiter.md
Name: fp_add_arbiter

Overview:
Two-requester round-robin arbiter and sequencer for the team's single combinational floating_point_addition datapath.
- Accepts operand pairs over valid/ready, registers them onto the shared adder inputs and waits ADDER_LAT cycles for settling.
- Captures {sign, exponent, sum} and returns it to the owning requester over valid/ready.
- Sits between the compute clients and the one adder instance; one operation is in flight at a time.

Parameters:
ADDER_LAT, 1, cycles operands are held stable on the adder before the result is sampled (must be >= 1)
DATA_W, 32, operand/result width (fixed 1/8/23 field split)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req0_valid  in  1  requester 0 has an operand pair
req0_ready  out  1  arbiter accepts requester 0 this cycle
req0_a, req0_b  in  32  requester 0 operands
resp0_valid  out  1  result for requester 0 available
resp0_ready  in  1  requester 0 takes result
req1_valid, req1_ready, req1_a, req1_b, resp1_valid, resp1_ready  (same as requester 0)
resp_result  out  32  {sign, exponent[7:0], sum[22:0]}; shared, qualified by resp0_valid/resp1_valid
flp_a, flp_b  out  32  operands to the adder
add_sign  in  1  adder sign
add_exponent  in  8  adder exponent
add_sum  in  23  adder fraction

Behaviour:
- Reset (async, rst_n=0) forces:
  - state=IDLE, flp_a=flp_b=0, resp_result=0
  - all ready/valid outputs 0, wait counter 0
  - last_grant=1, so requester 0 wins the first tie
- Reset mid-operation discards the in-flight op; no response is ever issued for it.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - Grant is combinational from the valid inputs: only one valid → that requester; both valid → the one != last_grant.
  - reqX_ready=1 only for the granted requester and only in IDLE; the other ready stays 0.
  - On the handshake edge (valid&ready): latch reqX_a/b into flp_a/flp_b, owner<=X, last_grant<=X, cnt<=ADDER_LAT-1, go WAIT.
- WAIT:
  - flp_a/flp_b held constant.
  - cnt decrements each cycle.
  - On the edge where cnt==0: resp_result<={add_sign,add_exponent,add_sum}, go RESP.
- RESP:
  - respX_valid=1 for the owner only; resp_result held stable.
  - Hold until respX_ready=1, then go IDLE on that edge.
  - No new request is accepted while in RESP.
- Latency: accept at edge k → respX_valid high after edge k+ADDER_LAT.
- Throughput: best case one op per ADDER_LAT+2 cycles (response taken in its first cycle).
- Fairness: with both requesters continuously valid, grants alternate 0,1,0,1...
- Boundary conditions:
  - Requester deasserting valid before grant: no effect, no op started.
  - resp_ready asserted while resp_valid=0: ignored.
  - flp_a/flp_b retain the last operands in IDLE (no toggling).
  - cnt width = max(1, clog2(ADDER_LAT)).
  - Both resp valids are never high simultaneously.
  - Operands are passed through unmodified; no special-value handling in this block.

Decomposition:
- Shared package holds:
  - field constants SIGN_BIT=31, EXP_MSB=30, EXP_LSB=23, FRAC_W=23
  - state encoding IDLE=2'd0, WAIT=2'd1, RESP=2'd2
- One natural sub-module: fp_rr_grant2 (combinational 2-way round-robin grant from valids + last_grant).
- The adder stays outside; it is connected at the parent level.

Test Plan:
All scenarios use the team adder connected, ADDER_LAT=1.
- Reset during WAIT: req0 accepted, rst_n pulsed low → all outputs 0 immediately; after release no resp0_valid ever appears.
- Single op, requester 0: req0_a=32'h02400000 (+12), req0_b=32'h030C0000 (+35) → req0_ready high in the acceptance cycle; resp0_valid one edge later; resp_result=32'h033C0000 (+47); resp1_valid stays 0.
- Simultaneous requests after reset: both valid → req0 granted first, req1 next after resp0 handshake; with both held valid for 4 ops, grant order is 0,1,0,1.
- Backpressure: resp1_ready held 0 for 5 cycles → resp1_valid and resp_result stable; req0_ready stays 0 throughout; a new op is accepted only after the resp1 handshake.
- ADDER_LAT=3 build: accept at edge k → resp valid exactly after edge k+3; flp_a/flp_b unchanged between edges k and k+3.
